// File: rtl/csr_trap_ctrl_pkg.sv
// Shared ISA definitions for the machine-mode CSR path.
// Covers CSR addresses, CSR file operations, SYSTEM instruction kinds and trap causes.
package isa_shared;

    localparam logic [11:0] MSTATUS  = 12'h300;
    localparam logic [11:0] MISA     = 12'h301;
    localparam logic [11:0] MIE      = 12'h304;
    localparam logic [11:0] MTVEC    = 12'h305;
    localparam logic [11:0] MSCRATCH = 12'h340;
    localparam logic [11:0] MEPC     = 12'h341;
    localparam logic [11:0] MCAUSE   = 12'h342;
    localparam logic [11:0] MTVAL    = 12'h343;
    localparam logic [11:0] MIP      = 12'h344;
    localparam logic [11:0] MHARTID  = 12'hF14;

    localparam logic [1:0] CSR_NONE  = 2'd0;
    localparam logic [1:0] CSR_WRITE = 2'd1;
    localparam logic [1:0] CSR_SET   = 2'd2;
    localparam logic [1:0] CSR_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        SYS_CSR    = 2'd0,
        SYS_ECALL  = 2'd1,
        SYS_EBREAK = 2'd2,
        SYS_MRET   = 2'd3
    } sys_kind_t;

    localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

endpackage

// File: rtl/csr_trap_ctrl_access_check.sv
// Combinational decode of a Zicsr instruction: write intent, legality and CSR file op.
module csr_access_check
    import isa_shared::*;
(
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1_idx,
    input  logic [11:0] csr_addr,
    output logic        write_intent,
    output logic        illegal,
    output logic [1:0]  op
);

    logic bad_funct3;
    logic read_only;

    // funct3[1:0] already matches the CSR_WRITE/SET/CLEAR encoding; 00 is not a CSR op.
    always_comb begin
        bad_funct3   = (funct3[1:0] == 2'b00);
        read_only    = (csr_addr[11:10] == 2'b11);
        write_intent = (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);
        illegal      = bad_funct3 || (write_intent && read_only);
        op           = CSR_NONE;
        if (write_intent && !illegal) begin
            op = funct3[1:0];
        end
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Sequencer between decode/execute and the CSR file: CSR accesses, trap entry and MRET.
// Every request finishes with a one-cycle done pulse carrying rd data or a PC redirect.
module csr_trap_ctrl
    import isa_shared::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_kind,
    input  logic [2:0]            req_funct3,
    input  logic [11:0]           req_csr,
    input  logic [4:0]            req_rs1_idx,
    input  logic [DATA_WIDTH-1:0] req_rs1_val,
    input  logic [31:0]           req_instr,
    input  logic [DATA_WIDTH-1:0] req_pc,
    input  logic                  exc_valid,
    input  logic [3:0]            exc_cause,
    input  logic [DATA_WIDTH-1:0] exc_value,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    output logic [11:0]           csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic [1:0]            csr_op,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  trap,
    output logic [3:0]            trap_cause,
    output logic [DATA_WIDTH-1:0] trap_value,
    output logic [DATA_WIDTH-1:0] trap_pc,
    input  logic                  trap_handled,
    input  logic [DATA_WIDTH-1:0] trap_target_pc,
    output logic                  done,
    output logic                  rd_we,
    output logic [DATA_WIDTH-1:0] rd_wdata,
    output logic                  redirect,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE,
        CSR_EXEC,
        TRAP_REQ,
        TRAP_WAIT,
        MRET_RD,
        MRET_WR,
        MRET_EPC,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [11:0]           addr_q, addr_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [4:0]            rd_idx_q, rd_idx_d;
    logic [3:0]            cause_q, cause_d;
    logic [DATA_WIDTH-1:0] tval_q, tval_d;
    logic [DATA_WIDTH-1:0] tpc_q, tpc_d;
    logic                  done_q, done_d;
    logic                  rd_we_q, rd_we_d;
    logic                  redirect_q, redirect_d;
    logic [DATA_WIDTH-1:0] rd_wdata_q, rd_wdata_d;
    logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    logic                  chk_write_intent;
    logic                  chk_illegal;
    logic [1:0]            chk_op;

    csr_access_check u_access_check (
        .funct3       (req_funct3),
        .rs1_idx      (req_rs1_idx),
        .csr_addr     (req_csr),
        .write_intent (chk_write_intent),
        .illegal      (chk_illegal),
        .op           (chk_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            op_q          <= CSR_NONE;
            wdata_q       <= '0;
            rd_idx_q      <= '0;
            cause_q       <= '0;
            tval_q        <= '0;
            tpc_q         <= '0;
            done_q        <= 1'b0;
            rd_we_q       <= 1'b0;
            redirect_q    <= 1'b0;
            rd_wdata_q    <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            op_q          <= op_d;
            wdata_q       <= wdata_d;
            rd_idx_q      <= rd_idx_d;
            cause_q       <= cause_d;
            tval_q        <= tval_d;
            tpc_q         <= tpc_d;
            done_q        <= done_d;
            rd_we_q       <= rd_we_d;
            redirect_q    <= redirect_d;
            rd_wdata_q    <= rd_wdata_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        op_d          = op_q;
        wdata_d       = wdata_q;
        rd_idx_d      = rd_idx_q;
        cause_d       = cause_q;
        tval_d        = tval_q;
        tpc_d         = tpc_q;
        done_d        = 1'b0;
        rd_we_d       = 1'b0;
        redirect_d    = 1'b0;
        rd_wdata_d    = rd_wdata_q;
        redirect_pc_d = redirect_pc_q;

        req_ready     = (state_q == IDLE) && !exc_valid;
        csr_addr      = '0;
        csr_op        = CSR_NONE;
        csr_wdata     = '0;
        trap          = 1'b0;
        trap_cause    = '0;
        trap_value    = '0;
        trap_pc       = '0;

        unique case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    cause_d = exc_cause;
                    tval_d  = exc_value;
                    tpc_d   = exc_pc;
                    state_d = TRAP_REQ;
                end else if (req_valid) begin
                    tpc_d  = req_pc;
                    tval_d = '0;
                    unique case (sys_kind_t'(req_kind))
                        SYS_CSR: begin
                            if (chk_illegal) begin
                                cause_d = CAUSE_ILLEGAL;
                                tval_d  = DATA_WIDTH'(req_instr);
                                state_d = TRAP_REQ;
                            end else begin
                                addr_d   = req_csr;
                                op_d     = chk_op;
                                wdata_d  = '0;
                                if (chk_write_intent) begin
                                    wdata_d = req_funct3[2] ? DATA_WIDTH'(req_rs1_idx) : req_rs1_val;
                                end
                                rd_idx_d = req_instr[11:7];
                                state_d  = CSR_EXEC;
                            end
                        end
                        SYS_ECALL: begin
                            cause_d = CAUSE_ECALL_M;
                            state_d = TRAP_REQ;
                        end
                        SYS_EBREAK: begin
                            cause_d = CAUSE_BREAKPOINT;
                            state_d = TRAP_REQ;
                        end
                        default: state_d = MRET_RD;
                    endcase
                end
            end
            // The CSR file applies csr_op on every cycle it is held, so this state lasts one cycle.
            CSR_EXEC: begin
                csr_addr   = addr_q;
                csr_op     = op_q;
                csr_wdata  = wdata_q;
                rd_wdata_d = csr_rdata;
                rd_we_d    = (rd_idx_q != 5'd0);
                done_d     = 1'b1;
                state_d    = DONE;
            end
            TRAP_REQ: begin
                trap       = 1'b1;
                trap_cause = cause_q;
                trap_value = tval_q;
                trap_pc    = tpc_q;
                state_d    = TRAP_WAIT;
            end
            TRAP_WAIT: begin
                if (trap_handled) begin
                    redirect_pc_d = trap_target_pc;
                    done_d        = 1'b1;
                    redirect_d    = 1'b1;
                    state_d       = DONE;
                end
            end
            MRET_RD: begin
                csr_addr                  = MSTATUS;
                wdata_d                   = csr_rdata;
                wdata_d[MSTATUS_MIE_BIT]  = csr_rdata[MSTATUS_MPIE_BIT];
                wdata_d[MSTATUS_MPIE_BIT] = 1'b1;
                wdata_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                state_d                   = MRET_WR;
            end
            MRET_WR: begin
                csr_addr  = MSTATUS;
                csr_op    = CSR_WRITE;
                csr_wdata = wdata_q;
                state_d   = MRET_EPC;
            end
            MRET_EPC: begin
                csr_addr      = MEPC;
                redirect_pc_d = csr_rdata & ~DATA_WIDTH'(3);
                done_d        = 1'b1;
                redirect_d    = 1'b1;
                state_d       = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done        = done_q;
    assign rd_we       = rd_we_q;
    assign rd_wdata    = rd_wdata_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a small behavioural machine-mode CSR file attached.
module tb_csr_trap_ctrl;
    import isa_shared::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_rs1_val;
    logic [31:0] req_instr;
    logic [31:0] req_pc;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_value;
    logic [31:0] exc_pc;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [1:0]  csr_op;
    logic [31:0] csr_rdata;
    logic        trap;
    logic [3:0]  trap_cause;
    logic [31:0] trap_value;
    logic [31:0] trap_pc;
    logic        trap_handled;
    logic [31:0] trap_target_pc;
    logic        done;
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic        redirect;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csr_trap_ctrl #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_kind       (req_kind),
        .req_funct3     (req_funct3),
        .req_csr        (req_csr),
        .req_rs1_idx    (req_rs1_idx),
        .req_rs1_val    (req_rs1_val),
        .req_instr      (req_instr),
        .req_pc         (req_pc),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_value      (exc_value),
        .exc_pc         (exc_pc),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_op         (csr_op),
        .csr_rdata      (csr_rdata),
        .trap           (trap),
        .trap_cause     (trap_cause),
        .trap_value     (trap_value),
        .trap_pc        (trap_pc),
        .trap_handled   (trap_handled),
        .trap_target_pc (trap_target_pc),
        .done           (done),
        .rd_we          (rd_we),
        .rd_wdata       (rd_wdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    // Behavioural CSR file: combinational read, op applied every clock it is held, trap registered.
    logic [31:0] m_mstatus  = 32'h0000_1800;
    logic [31:0] m_mtvec    = 32'h0;
    logic [31:0] m_mscratch = 32'h0;
    logic [31:0] m_mepc     = 32'h0;
    logic [31:0] m_mcause   = 32'h0;
    logic [31:0] m_mtval    = 32'h0;
    logic [31:0] m_mhartid  = 32'h5;
    int          wr_count   = 0;
    logic        handled_q;

    function automatic logic [31:0] apply_op(input logic [31:0] old, input logic [1:0] op,
                                             input logic [31:0] wd);
        case (op)
            CSR_WRITE: apply_op = wd;
            CSR_SET:   apply_op = old | wd;
            CSR_CLEAR: apply_op = old & ~wd;
            default:   apply_op = old;
        endcase
    endfunction

    always_comb begin
        case (csr_addr)
            MSTATUS:  csr_rdata = m_mstatus;
            MTVEC:    csr_rdata = m_mtvec;
            MSCRATCH: csr_rdata = m_mscratch;
            MEPC:     csr_rdata = m_mepc;
            MCAUSE:   csr_rdata = m_mcause;
            MTVAL:    csr_rdata = m_mtval;
            MHARTID:  csr_rdata = m_mhartid;
            default:  csr_rdata = 32'h0;
        endcase
    end

    assign trap_handled   = handled_q;
    assign trap_target_pc = m_mtvec & ~32'h3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) handled_q <= 1'b0;
        else        handled_q <= trap;
    end

    always @(posedge clk) begin
        if (trap) begin
            m_mepc    <= trap_pc;
            m_mcause  <= {28'h0, trap_cause};
            m_mtval   <= trap_value;
            m_mstatus <= {m_mstatus[31:13], 2'b11, m_mstatus[10:8], m_mstatus[3],
                          m_mstatus[6:4], 1'b0, m_mstatus[2:0]};
        end else if (csr_op != CSR_NONE) begin
            wr_count <= wr_count + 1;
            case (csr_addr)
                MSTATUS:  m_mstatus  <= apply_op(m_mstatus, csr_op, csr_wdata);
                MTVEC:    m_mtvec    <= apply_op(m_mtvec, csr_op, csr_wdata);
                MSCRATCH: m_mscratch <= apply_op(m_mscratch, csr_op, csr_wdata);
                MEPC:     m_mepc     <= apply_op(m_mepc, csr_op, csr_wdata);
                MHARTID:  m_mhartid  <= apply_op(m_mhartid, csr_op, csr_wdata);
                default:  ;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Offers one SYSTEM instruction for a single cycle; returns one step after the accepting edge.
    task automatic applyStimulus(input logic [1:0] kind, input logic [2:0] f3,
                                 input logic [11:0] csr, input logic [4:0] rs1,
                                 input logic [31:0] rs1_val, input logic [4:0] rd,
                                 input logic [31:0] pc);
        req_kind    = kind;
        req_funct3  = f3;
        req_csr     = csr;
        req_rs1_idx = rs1;
        req_rs1_val = rs1_val;
        req_pc      = pc;
        case (kind)
            SYS_CSR:    req_instr = {csr, rs1, f3, rd, 7'h73};
            SYS_ECALL:  req_instr = 32'h0000_0073;
            SYS_EBREAK: req_instr = 32'h0010_0073;
            default:    req_instr = 32'h3020_0073;
        endcase
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        int wr_before;
        logic seen_pulse;

        rst_n = 1'b0; req_valid = 1'b0; req_kind = '0; req_funct3 = '0; req_csr = '0;
        req_rs1_idx = '0; req_rs1_val = '0; req_instr = '0; req_pc = '0;
        exc_valid = 1'b0; exc_cause = '0; exc_value = '0; exc_pc = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        $display("[TB] reset state");
        checkOutput("reset_ready", req_ready, 1);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_op", csr_op, CSR_NONE);
        checkOutput("reset_trap", trap, 0);
        checkOutput("reset_rd_wdata", rd_wdata, 0);
        checkOutput("reset_redirect_pc", redirect_pc, 0);

        $display("[TB] CSRRW mscratch then CSRRS read-only");
        applyStimulus(SYS_CSR, 3'b001, MSCRATCH, 5'd6, 32'hDEAD_BEEF, 5'd1, 32'h40);
        checkOutput("rw_op", csr_op, CSR_WRITE);
        checkOutput("rw_addr", csr_addr, 12'h340);
        checkOutput("rw_wdata", csr_wdata, 32'hDEAD_BEEF);
        checkOutput("rw_done_early", done, 0);
        tick();
        checkOutput("rw_done", done, 1);
        checkOutput("rw_rd_we", rd_we, 1);
        checkOutput("rw_rd_wdata", rd_wdata, 0);
        checkOutput("rw_op_once", csr_op, CSR_NONE);
        checkOutput("rw_mscratch", m_mscratch, 32'hDEAD_BEEF);
        tick();
        checkOutput("rw_done_pulse", done, 0);
        checkOutput("rw_ready_again", req_ready, 1);
        applyStimulus(SYS_CSR, 3'b010, MSCRATCH, 5'd0, 32'h1234_5678, 5'd2, 32'h44);
        checkOutput("rs0_op", csr_op, CSR_NONE);
        checkOutput("rs0_addr", csr_addr, 12'h340);
        tick();
        checkOutput("rs0_rd_wdata", rd_wdata, 32'hDEAD_BEEF);
        checkOutput("rs0_mscratch", m_mscratch, 32'hDEAD_BEEF);
        tick();

        $display("[TB] CSRRSI / CSRRCI on mstatus");
        applyStimulus(SYS_CSR, 3'b110, MSTATUS, 5'd8, 32'hFFFF_FFFF, 5'd3, 32'h48);
        checkOutput("rsi_op", csr_op, CSR_SET);
        checkOutput("rsi_wdata", csr_wdata, 32'h8);
        tick();
        checkOutput("rsi_rd_wdata", rd_wdata, 32'h1800);
        checkOutput("rsi_mstatus", m_mstatus, 32'h1808);
        tick();
        applyStimulus(SYS_CSR, 3'b111, MSTATUS, 5'd8, 32'h0, 5'd3, 32'h4C);
        tick();
        checkOutput("rci_rd_wdata", rd_wdata, 32'h1808);
        checkOutput("rci_mstatus", m_mstatus, 32'h1800);
        tick();
        applyStimulus(SYS_CSR, 3'b110, MSTATUS, 5'd8, 32'h0, 5'd3, 32'h50);
        tick();
        tick();

        $display("[TB] mtvec write with rd=x0, then ECALL");
        applyStimulus(SYS_CSR, 3'b001, MTVEC, 5'd7, 32'h203, 5'd0, 32'h54);
        tick();
        checkOutput("mtvec_done", done, 1);
        checkOutput("mtvec_rd_we_x0", rd_we, 0);
        checkOutput("mtvec_value", m_mtvec, 32'h203);
        tick();
        applyStimulus(SYS_ECALL, 3'b000, 12'h0, 5'd0, 32'h0, 5'd0, 32'h100);
        checkOutput("ecall_trap", trap, 1);
        checkOutput("ecall_cause", trap_cause, 11);
        checkOutput("ecall_value", trap_value, 0);
        checkOutput("ecall_pc", trap_pc, 32'h100);
        tick();
        checkOutput("ecall_trap_once", trap, 0);
        checkOutput("ecall_done_early", done, 0);
        tick();
        checkOutput("ecall_done", done, 1);
        checkOutput("ecall_redirect", redirect, 1);
        checkOutput("ecall_redirect_pc", redirect_pc, 32'h200);
        checkOutput("ecall_mepc", m_mepc, 32'h100);
        checkOutput("ecall_mstatus", m_mstatus, 32'h1880);
        tick();

        $display("[TB] MRET");
        applyStimulus(SYS_MRET, 3'b000, 12'h0, 5'd0, 32'h0, 5'd0, 32'h300);
        checkOutput("mret_rd_addr", csr_addr, 12'h300);
        checkOutput("mret_rd_op", csr_op, CSR_NONE);
        tick();
        checkOutput("mret_wr_op", csr_op, CSR_WRITE);
        checkOutput("mret_wr_wdata", csr_wdata, 32'h1888);
        tick();
        checkOutput("mret_epc_addr", csr_addr, 12'h341);
        checkOutput("mret_done_early", done, 0);
        tick();
        checkOutput("mret_done", done, 1);
        checkOutput("mret_redirect", redirect, 1);
        checkOutput("mret_redirect_pc", redirect_pc, 32'h100);
        checkOutput("mret_mstatus", m_mstatus, 32'h1888);
        tick();

        $display("[TB] illegal accesses");
        wr_before = wr_count;
        applyStimulus(SYS_CSR, 3'b001, MHARTID, 5'd6, 32'hAAAA_0000, 5'd5, 32'h140);
        checkOutput("ro_trap", trap, 1);
        checkOutput("ro_cause", trap_cause, 2);
        checkOutput("ro_value", trap_value, 32'hF143_12F3);
        checkOutput("ro_op", csr_op, CSR_NONE);
        tick();
        tick();
        checkOutput("ro_redirect_pc", redirect_pc, 32'h200);
        checkOutput("ro_mhartid", m_mhartid, 32'h5);
        checkOutput("ro_no_write", wr_count, wr_before);
        tick();
        applyStimulus(SYS_CSR, 3'b100, MSCRATCH, 5'd1, 32'h0, 5'd1, 32'h144);
        checkOutput("f3_100_trap", trap, 1);
        checkOutput("f3_100_cause", trap_cause, 2);
        tick();
        tick();
        tick();

        $display("[TB] exception beats request");
        wr_before = wr_count;
        exc_valid = 1'b1; exc_cause = 4'd4; exc_value = 32'h1003; exc_pc = 32'h400;
        req_kind = SYS_CSR; req_funct3 = 3'b001; req_csr = MSCRATCH; req_rs1_idx = 5'd9;
        req_rs1_val = 32'h1234; req_instr = {MSCRATCH, 5'd9, 3'b001, 5'd1, 7'h73};
        req_valid = 1'b1;
        #1;
        checkOutput("exc_ready_low", req_ready, 0);
        tick();
        exc_valid = 1'b0;
        req_valid = 1'b0;
        checkOutput("exc_trap", trap, 1);
        checkOutput("exc_cause", trap_cause, 4);
        checkOutput("exc_value", trap_value, 32'h1003);
        checkOutput("exc_pc", trap_pc, 32'h400);
        tick();
        tick();
        checkOutput("exc_done", done, 1);
        checkOutput("exc_no_write", wr_count, wr_before);
        checkOutput("exc_mscratch", m_mscratch, 32'hDEAD_BEEF);
        tick();

        $display("[TB] reset during TRAP_WAIT");
        applyStimulus(SYS_EBREAK, 3'b000, 12'h0, 5'd0, 32'h0, 5'd0, 32'h180);
        checkOutput("ebreak_cause", trap_cause, 3);
        tick();
        checkOutput("ebreak_handled", trap_handled, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_done", done, 0);
        checkOutput("arst_redirect", redirect, 0);
        checkOutput("arst_rd_wdata", rd_wdata, 0);
        checkOutput("arst_redirect_pc", redirect_pc, 0);
        checkOutput("arst_trap", trap, 0);
        checkOutput("arst_csr_addr", csr_addr, 0);
        tick();
        rst_n = 1'b1;
        seen_pulse = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done || trap || redirect || (csr_op != CSR_NONE)) seen_pulse = 1'b1;
            tick();
        end
        checkOutput("arst_no_pulse", seen_pulse, 0);
        checkOutput("arst_ready", req_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Core-side initiator for the machine-mode CSR file. It accepts decoded SYSTEM instructions (CSRRW/S/C and immediate forms, ECALL, EBREAK, MRET) and pipeline exceptions from fetch/LSU. It sequences the single-cycle CSR accesses and trap-entry handshakes the CSR file expects, and returns rd write-back data or a PC redirect to the core. It sits between decode/execute and `csrfile`, and owns every `csr_*` and `trap*` input of that block.

## Interface
- DATA_WIDTH, 32, datapath width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  SYSTEM instruction offered
- req_ready  out  1  = (state==IDLE) & ~exc_valid
- req_kind  in  2  SYS_CSR / SYS_ECALL / SYS_EBREAK / SYS_MRET
- req_funct3  in  3  CSR variant (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
- req_csr  in  12  CSR address
- req_rs1_idx  in  5  rs1 index; zero-extended as zimm for immediate forms
- req_rs1_val  in  DATA_WIDTH  rs1 value
- req_instr  in  32  raw instruction word, used as mtval for illegal instructions
- req_pc  in  DATA_WIDTH  instruction PC
- exc_valid, exc_cause[3:0], exc_value[DW], exc_pc[DW]  in  pipeline exception
- csr_addr  out  12;  csr_wdata  out  DW;  csr_op  out  2;  csr_rdata  in  DW (combinational from CSR file)
- trap  out  1;  trap_cause  out  4;  trap_value  out  DW;  trap_pc  out  DW
- trap_handled  in  1;  trap_target_pc  in  DW
- done  out  1  one-cycle completion pulse
- rd_we  out  1;  rd_wdata  out  DW  write-back of the old CSR value
- redirect  out  1;  redirect_pc  out  DW  PC redirect, valid with done

## Operation
- FSM states: IDLE, CSR_EXEC, TRAP_REQ, TRAP_WAIT, MRET_RD, MRET_WR, MRET_EPC, DONE.
- IDLE:
  - exc_valid has priority. Latch cause, value and pc, then go to TRAP_REQ.
  - Otherwise, on req_valid, latch the request and decode it.
- Illegal instruction: go to TRAP_REQ with cause 2 and value=req_instr. Any of these is illegal:
  - SYS_CSR with funct3 000 or 100.
  - Write intent to a read-only CSR (req_csr[11:10]==2'b11).
- Write intent:
  - RW and RWI always write.
  - RS, RC, RSI and RCI write only when req_rs1_idx≠0.
  - With no write intent, csr_op=CSR_NONE; the read still happens.
- Write data: rs1_val for register forms, {27'b0,zimm} for immediate forms. Op is CSR_WRITE, CSR_SET or CSR_CLEAR.
- CSR_EXEC:
  - Drive addr/op/wdata for exactly one cycle, because the CSR file applies the op every cycle it is held.
  - Capture csr_rdata (the pre-write value) into rd_wdata.
  - rd_we=1 unless rd is x0; rd is req_instr[11:7].
  - Go to DONE.
- ECALL: cause 11. EBREAK: cause 3. Both use value 0 and trap_pc=req_pc.
- TRAP_REQ: trap=1 for one cycle with latched cause/value/pc, csr_op=CSR_NONE. Go to TRAP_WAIT.
- TRAP_WAIT:
  - Hold here until trap_handled.
  - On trap_handled, latch redirect_pc=trap_target_pc and go to DONE.
- MRET_RD: csr_addr=MSTATUS, op NONE. Latch mstatus.
- MRET_WR: CSR_WRITE to MSTATUS with MIE=MPIE, MPIE=1, MPP=2'b11, all other bits unchanged.
- MRET_EPC: csr_addr=MEPC, op NONE. Latch redirect_pc=csr_rdata & ~3.
- DONE: done=1 for one cycle; redirect=1 for trap and MRET. Then IDLE.
- Outputs when not actively driven: csr_addr=0, csr_op=CSR_NONE, csr_wdata=0, trap=0.
- req_valid while not ready is ignored.
- exc_valid while busy is the core's responsibility; the core stalls on ~req_ready.

## Timing
- Reset value of every output is 0; csr_op=CSR_NONE; state=IDLE.
- Reset mid-operation aborts the sequence. No trap or csr_op pulse is issued after reset release.
- Accept at cycle T. Latencies:
  - CSR: op at T+1, done/rd_we at T+2.
  - Trap: trap at T+1, trap_handled at T+2 (CSR file registers it), done/redirect at T+3.
  - MRET: done at T+4.
- done, rd_we and redirect are registered and high exactly one cycle.
- rd_wdata and redirect_pc hold until the next done.
- req_ready is combinational from state and exc_valid.
- A new request is accepted in the cycle after DONE.

## Structure
- isa_shared package holds:
  - CSR address constants (MSTATUS, MEPC, MTVEC, …).
  - CSR_NONE, CSR_WRITE, CSR_SET, CSR_CLEAR.
  - sys_kind_t.
  - Trap cause constants (CAUSE_ILLEGAL=2, CAUSE_BREAKPOINT=3, CAUSE_ECALL_M=11).
- The FSM state enum is local to the module.
- One combinational sub-module, csr_access_check: takes funct3, rs1_idx and csr address, and returns write_intent, illegal and op.

## Test plan
- CSRRW 0x340, rs1=0xDEADBEEF after reset:
  - csr_op=CSR_WRITE high one cycle, rd_wdata=0.
  - A following CSRRS 0x340 with rs1_idx=0 gives op NONE and rd_wdata=0xDEADBEEF.
- CSRRSI mstatus, zimm=8: mstatus becomes 0x1808. Then CSRRCI 8: mstatus 0x1800. Old values appear on rd_wdata.
- mtvec=0x203, ECALL at pc=0x100:
  - trap one cycle with cause 11, value 0.
  - redirect_pc=0x200 and done at T+3.
  - mepc=0x100.
- CSRRW to 0xF14 (mhartid):
  - No CSR write.
  - trap with cause 2 and trap_value=instruction word.
  - mhartid unchanged.
- After a trap (MIE=1 before the trap, so MPIE=1), MRET:
  - mstatus gets MIE=1, MPIE=1, MPP=11.
  - redirect_pc=mepc, done at T+4.
- exc_valid (cause 4, value 0x1003) together with req_valid CSRRW:
  - req_ready=0, the exception is trapped, and no CSR write occurs.
  - Separately, assert rst_n low during TRAP_WAIT: all outputs go to 0 and no done pulse follows.
